// File: rtl/bsg_manycore_mem_stream_tester.sv
`timescale 1ns/1ps
// bsg_manycore_mem_stream_tester
//
// Purpose: request-side traffic generator/checker placed directly upstream of
// a manycore memory endpoint. A pass writes num_words_p words with a known
// pattern, reads them back, and checks every return packet. The number of
// outstanding requests is bounded by max_out_credits_p.
//
// Request packet layout (MSB -> LSB):
//   addr[addr_width_p] | op[2] | op_ex[4] (store mask) | reg_id[5] |
//   payload[data_width_p] (load_info in the low bits for loads) |
//   src_y | src_x | dest_y | dest_x
// Return packet layout (MSB -> LSB):
//   pkt_type[2] | data[data_width_p] | reg_id[5] | y_cord | x_cord
//
// Ports:
//   clk_i, reset_i (async, active-high)
//   my_x_i/my_y_i        source coordinates placed in requests
//   dest_x_i/dest_y_i    target memory coordinates, latched on accepted start
//   start_i              begins a pass from IDLE or DONE
//   packet_o/_v_o/packet_ready_i            request channel
//   return_packet_i/_v_i/return_packet_yumi_o  return channel (always accepted)
//   busy_o, done_o, error_count_o (saturating)
module bsg_manycore_mem_stream_tester
  #(parameter int data_width_p = 32
  , parameter int addr_width_p = 16
  , parameter int x_cord_width_p = 4
  , parameter int y_cord_width_p = 4
  , parameter int num_words_p = 64
  , parameter int base_addr_p = 0
  , parameter logic [31:0] pattern_p = 32'hA5A5_5A5A
  , parameter int max_out_credits_p = 8
  , localparam int packet_width_lp = addr_width_p + 2 + 4 + 5 + data_width_p
                                     + 2*(x_cord_width_p + y_cord_width_p)
  , localparam int return_packet_width_lp = 2 + data_width_p + 5
                                            + x_cord_width_p + y_cord_width_p)
  (input  logic                              clk_i
  , input  logic                              reset_i
  , input  logic [x_cord_width_p-1:0]         my_x_i
  , input  logic [y_cord_width_p-1:0]         my_y_i
  , input  logic [x_cord_width_p-1:0]         dest_x_i
  , input  logic [y_cord_width_p-1:0]         dest_y_i
  , input  logic                              start_i
  , output logic [packet_width_lp-1:0]        packet_o
  , output logic                              packet_v_o
  , input  logic                              packet_ready_i
  , input  logic [return_packet_width_lp-1:0] return_packet_i
  , input  logic                              return_packet_v_i
  , output logic                              return_packet_yumi_o
  , output logic                              busy_o
  , output logic                              done_o
  , output logic [15:0]                       error_count_o
  );

  localparam int idx_w_lp    = $clog2(num_words_p + 1);
  localparam int credit_w_lp = $clog2(max_out_credits_p + 1);
  localparam int cord_w_lp   = x_cord_width_p + y_cord_width_p;

  localparam logic [idx_w_lp-1:0]    last_idx_lp    = idx_w_lp'(num_words_p - 1);
  localparam logic [credit_w_lp-1:0] max_credits_lp = credit_w_lp'(max_out_credits_p);

  localparam logic [1:0] e_remote_load    = 2'd0;
  localparam logic [1:0] e_remote_store   = 2'd1;
  localparam logic [1:0] e_return_credit  = 2'd0;
  localparam logic [1:0] e_return_int_wb  = 2'd1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] STORE   = 3'd1;
  localparam logic [2:0] DRAIN_S = 3'd2;
  localparam logic [2:0] LOAD    = 3'd3;
  localparam logic [2:0] DRAIN_L = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  function automatic logic [data_width_p-1:0] word_data(input logic [idx_w_lp-1:0] k);
    return data_width_p'(pattern_p) ^ data_width_p'(k);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]                state_r;
  logic [idx_w_lp-1:0]       tx_idx_r;
  logic [idx_w_lp-1:0]       rx_idx_r;
  logic [credit_w_lp-1:0]    credits_r;
  logic [15:0]               err_cnt_r;
  logic [x_cord_width_p-1:0] dest_x_r;
  logic [y_cord_width_p-1:0] dest_y_r;

  logic busy, issuing, start_ok, req_hs, ret_hs, credit_inc, ret_bad;

  assign busy     = (state_r == STORE) || (state_r == DRAIN_S)
                 || (state_r == LOAD)  || (state_r == DRAIN_L);
  assign issuing  = (state_r == STORE) || (state_r == LOAD);
  assign start_ok = start_i && ((state_r == IDLE) || (state_r == DONE));

  assign packet_v_o           = issuing && (credits_r != '0);
  assign req_hs               = packet_v_o && packet_ready_i;
  assign return_packet_yumi_o = return_packet_v_i;
  assign ret_hs               = return_packet_v_i;
  // A return outside a pass, or one beyond the outstanding count, must not
  // push the credit count past its maximum.
  assign credit_inc           = ret_hs && busy && (credits_r != max_credits_lp);

  assign busy_o        = busy;
  assign done_o        = (state_r == DONE);
  assign error_count_o = err_cnt_r;

  logic [1:0]              ret_type;
  logic [data_width_p-1:0] ret_data;
  logic [4:0]              ret_reg;
  assign ret_type = return_packet_i[return_packet_width_lp-1 -: 2];
  assign ret_data = return_packet_i[return_packet_width_lp-3 -: data_width_p];
  assign ret_reg  = return_packet_i[cord_w_lp +: 5];
  wire unused_ret_cord = ^return_packet_i[cord_w_lp-1:0];

  always_comb begin
    ret_bad = 1'b0;
    case (state_r)
      STORE, DRAIN_S: ret_bad = (ret_type != e_return_credit);
      LOAD, DRAIN_L:  ret_bad = (ret_type != e_return_int_wb)
                             || (ret_reg != 5'(rx_idx_r))
                             || (ret_data != word_data(rx_idx_r));
      default:        ret_bad = 1'b1;
    endcase
  end

  logic [addr_width_p-1:0] pkt_addr;
  logic [1:0]              pkt_op;
  logic [3:0]              pkt_op_ex;
  logic [4:0]              pkt_reg;
  logic [data_width_p-1:0] pkt_payload;

  always_comb begin
    pkt_addr = addr_width_p'(base_addr_p) + addr_width_p'(tx_idx_r);
    if (state_r == LOAD) begin
      pkt_op      = e_remote_load;
      pkt_op_ex   = 4'h0;
      pkt_reg     = 5'(tx_idx_r);
      pkt_payload = '0;
    end else begin
      pkt_op      = e_remote_store;
      pkt_op_ex   = 4'hF;
      pkt_reg     = 5'd0;
      pkt_payload = word_data(tx_idx_r);
    end
  end

  assign packet_o = {pkt_addr, pkt_op, pkt_op_ex, pkt_reg, pkt_payload,
                     my_y_i, my_x_i, dest_y_r, dest_x_r};

  always_ff @(posedge clk_i) begin
    if (start_ok) begin
      dest_x_r <= dest_x_i;
      dest_y_r <= dest_y_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      tx_idx_r  <= '0;
      rx_idx_r  <= '0;
      credits_r <= max_credits_lp;
      err_cnt_r <= '0;
    end else if (start_ok) begin
      state_r   <= STORE;
      tx_idx_r  <= '0;
      rx_idx_r  <= '0;
      credits_r <= max_credits_lp;
      err_cnt_r <= '0;
    end else begin
      if (ret_hs && ret_bad)
        err_cnt_r <= sat_inc(err_cnt_r);
      if (ret_hs && busy)
        rx_idx_r <= rx_idx_r + 1'b1;

      case ({req_hs, credit_inc})
        2'b10:   credits_r <= credits_r - 1'b1;
        2'b01:   credits_r <= credits_r + 1'b1;
        default: credits_r <= credits_r;
      endcase

      case (state_r)
        STORE, LOAD: begin
          if (req_hs) begin
            if (tx_idx_r == last_idx_lp)
              state_r <= (state_r == STORE) ? DRAIN_S : DRAIN_L;
            else
              tx_idx_r <= tx_idx_r + 1'b1;
          end
        end
        DRAIN_S: begin
          // The registered count reaching max means every store return has
          // been consumed, including one that coincided with the last store.
          if (credits_r == max_credits_lp) begin
            state_r  <= LOAD;
            tx_idx_r <= '0;
            rx_idx_r <= '0;
          end
        end
        DRAIN_L: begin
          if (credits_r == max_credits_lp)
            state_r <= DONE;
        end
        IDLE, DONE: state_r <= state_r;
        default:    state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_manycore_mem_stream_tester.sv
`timescale 1ns/1ps
module tb_bsg_manycore_mem_stream_tester;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int PW = AW + 2 + 4 + 5 + DW + 2*(XW + YW);
  localparam int RW = 2 + DW + 5 + XW + YW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [XW-1:0] my_x_i, dest_x_i;
  logic [YW-1:0] my_y_i, dest_y_i;
  logic          start_i;
  logic [PW-1:0] packet_o;
  logic          packet_v_o;
  logic          packet_ready_i = 1'b1;
  logic [RW-1:0] return_packet_i = '0;
  logic          return_packet_v_i = 1'b0;
  logic          return_packet_yumi_o;
  logic          busy_o, done_o;
  logic [15:0]   error_count_o;

  bsg_manycore_mem_stream_tester #(
    .data_width_p(DW), .addr_width_p(AW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .num_words_p(4), .base_addr_p(16'h0100), .pattern_p(32'hA5A5_5A5A),
    .max_out_credits_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .my_x_i(my_x_i), .my_y_i(my_y_i), .dest_x_i(dest_x_i), .dest_y_i(dest_y_i),
    .start_i(start_i),
    .packet_o(packet_o), .packet_v_o(packet_v_o), .packet_ready_i(packet_ready_i),
    .return_packet_i(return_packet_i), .return_packet_v_i(return_packet_v_i),
    .return_packet_yumi_o(return_packet_yumi_o),
    .busy_o(busy_o), .done_o(done_o), .error_count_o(error_count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard of expected request packets and memory model state
  logic [PW-1:0] exp_q[$];
  logic [RW-1:0] rq[$];
  logic [31:0]   mem [logic [15:0]];

  logic mem_hold = 1'b0;
  logic corrupt  = 1'b0;
  logic rdy_rand = 1'b0;
  int   inj_cnt  = 0;
  int   inj_seen = 0;
  logic ret_from_q = 1'b0;
  int   hs_cnt   = 0;
  int   load_cnt = 0;

  function automatic logic [PW-1:0] mk_req(input logic [15:0] a, input logic [1:0] op,
                                           input logic [3:0] ex, input logic [4:0] rg,
                                           input logic [31:0] pl);
    return {a, op, ex, rg, pl, 4'd2, 4'd1, 4'd4, 4'd3};
  endfunction

  task automatic push_pass();
    logic [31:0] d [4];
    d[0] = 32'hA5A55A5A; d[1] = 32'hA5A55A5B; d[2] = 32'hA5A55A58; d[3] = 32'hA5A55A59;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk_req(16'h0100 + 16'(k), 2'd1, 4'hF, 5'd0, d[k]));
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk_req(16'h0100 + 16'(k), 2'd0, 4'h0, 5'(k), 32'd0));
  endtask

  // Return-path driver and ready generator
  logic [15:0] lfsr = 16'hACE1;
  always @(posedge clk) begin
    #1;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    packet_ready_i = rdy_rand ? lfsr[0] : 1'b1;
    if (inj_cnt != inj_seen) begin
      inj_seen          = inj_cnt;
      return_packet_i   = '0;
      return_packet_v_i = 1'b1;
      ret_from_q        = 1'b0;
    end else if (!mem_hold && rq.size() > 0) begin
      return_packet_i   = rq[0];
      return_packet_v_i = 1'b1;
      ret_from_q        = 1'b1;
    end else begin
      return_packet_v_i = 1'b0;
      ret_from_q        = 1'b0;
    end
  end

  // Monitor: request scoreboard, memory model, return consumption, stability
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_pkt;
  always @(negedge clk) begin
    logic [15:0] a;
    logic [31:0] dd;
    if (reset_i) begin
      rq.delete();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_v", packet_v_o, 1'b1);
        chk("hold_pkt", packet_o, prev_pkt);
      end
      if (return_packet_v_i) begin
        chk("yumi", return_packet_yumi_o, 1'b1);
        if (ret_from_q) void'(rq.pop_front());
      end
      if (packet_v_o && packet_ready_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected: got %0h expected none", packet_o);
        end else begin
          chk("req", packet_o, exp_q.pop_front());
        end
        a = packet_o[PW-1 -: 16];
        if (packet_o[58:57] == 2'd1) begin
          mem[a] = packet_o[47:16];
          rq.push_back({2'd0, 32'd0, 5'd0, 8'd0});
        end else begin
          load_cnt++;
          dd = mem.exists(a) ? mem[a] : 32'd0;
          if (corrupt && a == 16'h0102) dd = dd ^ 32'd1;
          rq.push_back({2'd1, dd, packet_o[52:48], 8'd0});
        end
      end
      prev_stall = packet_v_o && !packet_ready_i;
      prev_pkt   = packet_o;
    end
  end

  task automatic do_start();
    push_pass();
    @(posedge clk); #2 start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
    chk("start_v", packet_v_o, 1'b1);
    chk("start_busy", busy_o, 1'b1);
    chk("start_err_clr", error_count_o, 16'd0);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) begin
      total++; bad++;
      $display("FAIL %s_timeout: got done=0 expected done=1", nm);
    end
  endtask

  initial begin
    int hs0, lc0, n;
    reset_i = 1'b1; start_i = 1'b0;
    my_x_i = 4'd1; my_y_i = 4'd2; dest_x_i = 4'd3; dest_y_i = 4'd4;
    repeat (3) @(negedge clk);
    chk("rst_v", packet_v_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", error_count_o, 16'd0);
    reset_i = 1'b0;

    // Ideal memory, ready always high
    do_start();
    wait_done("pass1");
    chk("p1_done", done_o, 1'b1);
    chk("p1_busy", busy_o, 1'b0);
    chk("p1_err", error_count_o, 16'd0);
    chk("p1_all_req", 32'(exp_q.size()), 32'd0);

    // Spurious return in DONE, then start clears it; random ready; start ignored mid-pass
    @(negedge clk); inj_cnt++;
    repeat (3) @(negedge clk);
    chk("done_spurious_err", error_count_o, 16'd1);
    rdy_rand = 1'b1;
    do_start();
    @(posedge clk); #2 start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
    wait_done("pass_rand");
    chk("rand_err", error_count_o, 16'd0);
    chk("rand_all_req", 32'(exp_q.size()), 32'd0);
    rdy_rand = 1'b0;

    // Credit limit with returns withheld
    @(negedge clk);
    mem_hold = 1'b1;
    hs0 = hs_cnt;
    do_start();
    repeat (8) @(negedge clk);
    chk("credit_issued", 32'(hs_cnt - hs0), 32'd2);
    chk("credit_stall_v", packet_v_o, 1'b0);
    mem_hold = 1'b0;
    @(negedge clk);
    chk("credit_ret_v", return_packet_v_i, 1'b1);
    chk("credit_still_stalled", packet_v_o, 1'b0);
    @(negedge clk);
    chk("credit_resume_v", packet_v_o, 1'b1);
    wait_done("pass_credit");
    chk("credit_err", error_count_o, 16'd0);

    // Corrupted load data for word 2
    corrupt = 1'b1;
    do_start();
    wait_done("pass_corrupt");
    chk("corrupt_err", error_count_o, 16'd1);
    corrupt = 1'b0;

    // Reset during LOAD
    lc0 = load_cnt;
    do_start();
    n = 0;
    while (load_cnt == lc0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_load", 32'(load_cnt > lc0), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("midrst_v", packet_v_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_done", done_o, 1'b0);
    chk("midrst_err", error_count_o, 16'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    do_start();
    wait_done("pass_after_rst");
    chk("after_rst_done", done_o, 1'b1);
    chk("after_rst_err", error_count_o, 16'd0);

    // Spurious return in IDLE
    @(negedge clk); reset_i = 1'b1;
    @(negedge clk); reset_i = 1'b0;
    inj_cnt++;
    repeat (3) @(negedge clk);
    chk("idle_spurious_err", error_count_o, 16'd1);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_done", done_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_mem_stream_tester.md
# bsg_manycore_mem_stream_tester

Request-side traffic generator and checker that sits directly upstream of a manycore memory endpoint (e.g. an infinite-capacity test memory). On `start_i` it streams `num_words_p` remote stores of a known pattern, then `num_words_p` remote loads of the same addresses, and checks every return packet for type, reg_id and data. It uses the endpoint's packet-level out-request/in-return interface and respects a credit limit on outstanding requests.

## Interface
- `data_width_p`, "inv", payload/data width (≥16).
- `addr_width_p`, "inv", packet word-address width.
- `x_cord_width_p` / `y_cord_width_p`, "inv", coordinate widths.
- `num_words_p`, 64, words per pass (≥1).
- `base_addr_p`, 0, first word address.
- `pattern_p`, 32'hA5A5_5A5A, data seed; truncated/zero-extended to `data_width_p`.
- `max_out_credits_p`, 8, max outstanding requests (≥1).

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `my_x_i` / `my_y_i`  in  x/y width  source coordinates placed in requests.
- `dest_x_i` / `dest_y_i`  in  x/y width  target memory coordinates; sampled on accepted `start_i`.
- `start_i`  in  1  begin a pass; honoured only in IDLE or DONE.
- `packet_o`  out  packet_s  request packet.
- `packet_v_o`  out  1  request valid.
- `packet_ready_i`  in  1  endpoint accepts when `packet_v_o & packet_ready_i`.
- `return_packet_i`  in  return_packet_s  response.
- `return_packet_v_i`  in  1  response valid.
- `return_packet_yumi_o`  out  1  response consumed.
- `busy_o`  out  1  pass in progress.
- `done_o`  out  1  pass finished; held until next start.
- `error_count_o`  out  16  saturating mismatch count.

## Operation
- Word k (0..num_words_p-1): addr = base_addr_p + k; data_k = pattern_p ^ k (k zero-extended).
- Store request: op e_remote_store, store_mask all ones, payload data_k, reg_id 0, src = my_x/y, dest = latched dest.
- Load request: op e_remote_load, load_info all zero (word, signed, int wb, not ifetch), reg_id = k[4:0].
- FSM: IDLE -start-> STORE (tx_idx, rx_idx, error_count cleared; credits = max). STORE: issue stores; after last store handshake -> DRAIN_S. DRAIN_S: when credits == max -> LOAD (tx_idx, rx_idx cleared). LOAD: issue loads; after last -> DRAIN_L. DRAIN_L: credits == max -> DONE. DONE -start-> STORE as from IDLE.
- `packet_v_o` = (STORE|LOAD) & credits != 0; never depends on `packet_ready_i`.
- Credits: −1 on request handshake, +1 on return consumed; both same cycle → unchanged. Never exceeds max, never below 0.
- `return_packet_yumi_o` = `return_packet_v_i` (always accept).
- Returns arrive in order. In STORE/DRAIN_S: expected pkt_type e_return_credit. In LOAD/DRAIN_L: expected e_return_int_wb, reg_id == rx_idx[4:0], data == data_rx_idx. rx_idx increments per return. Any field mismatch → error_count +1 (one per packet), saturating at 16'hFFFF.
- Return in IDLE or DONE: consumed, counted as error, credits unchanged.
- `start_i` during STORE..DRAIN_L ignored.
- `busy_o` high in STORE..DRAIN_L; `done_o` high only in DONE.

## Timing
- Reset (async assert, release synchronous to `clk_i`): state IDLE, `packet_v_o`=0, `busy_o`=0, `done_o`=0, `error_count_o`=0, credits=max, indices 0. Reset mid-pass aborts immediately; outstanding returns after reset count as errors in IDLE.
- `packet_o`, `packet_v_o` combinational from registered state/indices; one request per cycle max.
- start accepted at edge N → first request valid in cycle N+1.
- With zero-latency memory and ready always 1, one store per cycle; error_count updates the edge after the return handshake.
- Last-store handshake and first return in DRAIN_S may coincide; transition to LOAD only when the credit count has returned to max.

## Test plan
- num_words_p=4, ideal memory, ready=1: 4 stores then 4 loads; load data A5A55A5A, A5A55A5B, A5A55A58, A5A55A59; done_o=1, error_count_o=0.
- max_out_credits_p=2, memory returns withheld: packet_v_o drops after 2 issued; resumes one cycle after each return.
- ready toggled pseudo-randomly: packet_o held stable while v & ~ready; final error_count_o=0.
- Memory corrupts word 2 load data: error_count_o=1 at done.
- Assert reset_i during LOAD: outputs return to reset values asynchronously; then start → full clean pass, done_o=1.
- Inject spurious return in IDLE: consumed same cycle, error_count_o=1; start pulsed in STORE ignored; start in DONE clears count.
